pulse_input_conditioner: RTL
============================

// Module: pulse_input_conditioner
// PURPOSE
//   Front-end stage that drives IN_PULSE of the pulse shortening device.
//   Synchronises an asynchronous raw pulse line into IN_CLOCK and rejects glitches shorter than a programmable width.
//   Emits a clean level plus one-cycle rise/fall strobes.
//   OUT_CLEAN connects directly to the shortener's IN_PULSE; sub-period glitches never reach it.
// PARAMETERS
//   SYNC_STAGES      2   synchroniser flops on IN_RAW; must be >= 2
//   MIN_HIGH_CYCLES  3   consecutive high samples needed to accept a rise; must be >= 1
//   MIN_LOW_CYCLES   3   consecutive low samples needed to accept a fall; must be >= 1
//   GLITCH_CNT_W     16  width of OUT_GLITCH_COUNT (only with GLITCH_COUNT_EN)
// PORTS
//   IN_CLOCK          in   1             system clock, rising edge
//   IN_RESET_N        in   1             reset, synchronous, active-low
//   IN_RAW            in   1             asynchronous raw pulse input
//   OUT_CLEAN         out  1             qualified, synchronised pulse level
//   OUT_RISE          out  1             1-cycle strobe on accepted rise
//   OUT_FALL          out  1             1-cycle strobe on accepted fall
//   OUT_GLITCH_COUNT  out  GLITCH_CNT_W  rejected-glitch count (GLITCH_COUNT_EN only)
// BEHAVIOUR
// - Reset:
//   - IN_RESET_N sampled low at an edge clears everything at that edge.
//   - Cleared items: sync chain, qualification counter, OUT_CLEAN, OUT_RISE, OUT_FALL, OUT_GLITCH_COUNT.
//   - FSM goes to LOW.
// - Synchroniser:
//   - sync[0] <= IN_RAW; sync[i] <= sync[i-1].
//   - s = sync[SYNC_STAGES-1].
//   - No other logic touches IN_RAW.
// - FSM states LOW, QUAL_H, HIGH, QUAL_L; the counter counts consecutive qualifying samples of s.
//   - LOW: s=1 -> QUAL_H, cnt=1.
//     If MIN_HIGH_CYCLES=1, go straight to HIGH.
//   - QUAL_H: s=0 -> LOW, glitch rejected.
//     If s=1 and cnt+1=MIN_HIGH_CYCLES -> HIGH; otherwise cnt++.
//   - HIGH: s=0 -> QUAL_L, cnt=1.
//     If MIN_LOW_CYCLES=1, go straight to LOW.
//   - QUAL_L: s=1 -> HIGH, glitch rejected.
//     If s=0 and cnt+1=MIN_LOW_CYCLES -> LOW; otherwise cnt++.
// - Outputs are registered on the same edge as the state change:
//   - entering HIGH: OUT_CLEAN<=1, OUT_RISE<=1 for one cycle.
//   - entering LOW from QUAL_L: OUT_CLEAN<=0, OUT_FALL<=1 for one cycle.
//   - OUT_RISE and OUT_FALL are never high together.
// - Latency:
//   - IN_RAW first sampled high at edge N -> OUT_CLEAN high after edge N+SYNC_STAGES+MIN_HIGH_CYCLES-1.
//   - Falling edge is symmetric with MIN_LOW_CYCLES.
// - Pulse width:
//   - Accepted pulses keep their sampled width.
//   - Rejected high pulses are shorter than MIN_HIGH_CYCLES samples; rejected low dropouts are shorter than MIN_LOW_CYCLES.
//   - Pulses narrower than one period that no edge samples are invisible.
// - Counter sized $clog2(max(MIN_HIGH,MIN_LOW))+1; it never wraps.
// - Boundary cases:
//   - IN_RAW already high at reset release: treated as a normal rise; OUT_RISE fires after the full latency.
//   - Reset asserted while OUT_CLEAN=1: OUT_CLEAN goes 0 at that edge with no OUT_FALL strobe.
//   - Reset asserted during QUAL_*: discarded, not counted as a glitch.
//   - A toggle at the last qualifying sample counts as rejection; the state reverts.
// CONFIGURATION
// - Macro PULSE_INPUT_CONDITIONER_GLITCH_COUNT_EN.
// - Defined:
//   - OUT_GLITCH_COUNT exists.
//   - Incremented by 1 on each QUAL_H->LOW and each QUAL_L->HIGH transition.
//   - Saturates at all-ones; cleared only by reset.
// - Undefined: the port and counter are absent; all other behaviour is identical.
// TESTING
// Defaults; 50 MHz clock, 20 ns period; latency 4 edges.
// - T1, reset with raw high:
//   - IN_RESET_N=0 for 3 edges, IN_RAW=1 -> all outputs 0.
//   - Release -> OUT_RISE=1 for exactly one cycle and OUT_CLEAN=1 after the 4th edge following release.
// - T2, nominal pulse: IN_RAW high for 5 cycles -> OUT_CLEAN high for exactly 5 cycles, shifted 4 edges.
//   - One OUT_RISE, one OUT_FALL.
//   - Glitch count 0.
// - T3, short pulse: IN_RAW high for 2 sampled cycles -> OUT_CLEAN stays 0, no strobes.
//   - OUT_GLITCH_COUNT=1.
// - T4, sub-period glitch: IN_RAW high for 5 ns entirely between edges -> no output activity.
//   - Count unchanged.
// - T5, low dropout: 1-cycle low dropout inside a 10-cycle high -> OUT_CLEAN stays 1 throughout.
//   - No OUT_FALL during the dropout.
//   - Count +1.
// - T6, reset mid-pulse: IN_RESET_N=0 while OUT_CLEAN=1 -> OUT_CLEAN=0 at that edge, OUT_FALL never asserted.
//   - Count reads 0.

Source files
------------

// File: rtl/pulse_input_conditioner.sv
// pulse_input_conditioner: synchronises a raw asynchronous pulse line and
// rejects high pulses / low dropouts shorter than a programmable sample count.
// Produces a clean level plus one-cycle rise/fall strobes.
// Optional feature macro: PULSE_INPUT_CONDITIONER_GLITCH_COUNT_EN adds the
// saturating rejected-glitch counter and its OUT_GLITCH_COUNT port.
module pulse_input_conditioner #(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned MIN_HIGH_CYCLES = 3,
    parameter int unsigned MIN_LOW_CYCLES  = 3,
    parameter int unsigned GLITCH_CNT_W    = 16
) (
    input  logic                    IN_CLOCK,
    input  logic                    IN_RESET_N,
    input  logic                    IN_RAW,
    output logic                    OUT_CLEAN,
    output logic                    OUT_RISE,
    output logic                    OUT_FALL
`ifdef PULSE_INPUT_CONDITIONER_GLITCH_COUNT_EN
    ,
    output logic [GLITCH_CNT_W-1:0] OUT_GLITCH_COUNT
`endif
);

    localparam int unsigned MAX_MIN = (MIN_HIGH_CYCLES > MIN_LOW_CYCLES) ?
                                      MIN_HIGH_CYCLES : MIN_LOW_CYCLES;
    localparam int unsigned CNT_W   = $clog2(MAX_MIN) + 1;

    // cnt holds the number of qualifying samples already seen, so the final
    // qualifying sample arrives while cnt equals MIN_*_CYCLES-1.
    localparam logic [CNT_W-1:0] HIGH_LAST = CNT_W'(MIN_HIGH_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOW_LAST  = CNT_W'(MIN_LOW_CYCLES - 1);

    typedef enum logic [1:0] {
        LOW    = 2'd0,
        QUAL_H = 2'd1,
        HIGH   = 2'd2,
        QUAL_L = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] sync;
    logic                   s;
    state_t                 state, state_n;
    logic [CNT_W-1:0]       cnt, cnt_n;
    logic                   clean_n, rise_n, fall_n;

    assign s = sync[SYNC_STAGES-1];

    // Synchroniser chain: the only logic that touches IN_RAW.
    always_ff @(posedge IN_CLOCK) begin
        if (!IN_RESET_N) begin
            sync <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], IN_RAW};
        end
    end

    // State, counter and registered outputs update together.
    always_ff @(posedge IN_CLOCK) begin
        if (!IN_RESET_N) begin
            state     <= LOW;
            cnt       <= '0;
            OUT_CLEAN <= 1'b0;
            OUT_RISE  <= 1'b0;
            OUT_FALL  <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            OUT_CLEAN <= clean_n;
            OUT_RISE  <= rise_n;
            OUT_FALL  <= fall_n;
        end
    end

    // Next-state, counter and output decode for the qualification FSM.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        clean_n = OUT_CLEAN;
        rise_n  = 1'b0;
        fall_n  = 1'b0;
        unique case (state)
            LOW: begin
                if (s) begin
                    if (MIN_HIGH_CYCLES == 1) begin
                        state_n = HIGH;
                        clean_n = 1'b1;
                        rise_n  = 1'b1;
                    end else begin
                        state_n = QUAL_H;
                        cnt_n   = CNT_W'(1);
                    end
                end
            end
            QUAL_H: begin
                if (!s) begin
                    state_n = LOW;
                end else if (cnt == HIGH_LAST) begin
                    state_n = HIGH;
                    clean_n = 1'b1;
                    rise_n  = 1'b1;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            HIGH: begin
                if (!s) begin
                    if (MIN_LOW_CYCLES == 1) begin
                        state_n = LOW;
                        clean_n = 1'b0;
                        fall_n  = 1'b1;
                    end else begin
                        state_n = QUAL_L;
                        cnt_n   = CNT_W'(1);
                    end
                end
            end
            QUAL_L: begin
                if (s) begin
                    state_n = HIGH;
                end else if (cnt == LOW_LAST) begin
                    state_n = LOW;
                    clean_n = 1'b0;
                    fall_n  = 1'b1;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_n = LOW;
            end
        endcase
    end

`ifdef PULSE_INPUT_CONDITIONER_GLITCH_COUNT_EN
    logic rejected;

    // A rejection is an aborted qualification; reset takes priority below,
    // so a qualification cut short by reset is never counted.
    assign rejected = ((state == QUAL_H) && !s) || ((state == QUAL_L) && s);

    // Saturating rejected-glitch counter, cleared only by reset.
    always_ff @(posedge IN_CLOCK) begin
        if (!IN_RESET_N) begin
            OUT_GLITCH_COUNT <= '0;
        end else if (rejected && (OUT_GLITCH_COUNT != '1)) begin
            OUT_GLITCH_COUNT <= OUT_GLITCH_COUNT + GLITCH_CNT_W'(1);
        end
    end
`endif

endmodule
